// File: rtl/wb_host_arbiter.sv
// Two-master Wishbone arbiter: management WB (A) and logic-analyzer debug master (B) share one slave port.
// Latency: grant -> m_stb_o next cycle; m_ack_i -> master ack/done next cycle; 3 cycles best case from request.
// Backpressure: one downstream cycle at a time; losers wait in IDLE, watchdog ends hung slave cycles.
module wb_host_arbiter #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            TMO_W    = 8,
    parameter logic [DW-1:0] ERR_DATA = DW'(32'hBADC0DE5)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // master A: management Wishbone
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [DW/8-1:0]   wbs_sel_i,
    input  logic [AW-1:0]     wbs_adr_i,
    input  logic [DW-1:0]     wbs_dat_i,
    output logic [DW-1:0]     wbs_dat_o,
    output logic              wbs_ack_o,
    // master B: logic-analyzer debug master
    input  logic              la_req_i,
    input  logic              la_we_i,
    input  logic [DW/8-1:0]   la_sel_i,
    input  logic [AW-1:0]     la_adr_i,
    input  logic [DW-1:0]     la_dat_i,
    output logic [DW-1:0]     la_dat_o,
    output logic              la_done_o,
    output logic              la_err_o,
    // downstream slave port
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [DW/8-1:0]   m_sel_o,
    output logic [AW-1:0]     m_adr_o,
    output logic [DW-1:0]     m_dat_o,
    input  logic [DW-1:0]     m_dat_i,
    input  logic              m_ack_i,
    // status
    output logic              tmo_sticky_o,
    output logic [1:0]        grant_o
);

    localparam int SW = DW / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The counter holds (BUSY cycles so far - 1); when it sits at all-ones minus one the
    // current BUSY cycle is the (2**TMO_W-1)-th, which is the last one allowed.
    localparam logic [TMO_W-1:0] WD_EXPIRE = TMO_W'((2 ** TMO_W) - 2);

    // owner / rr_last encoding: 0 = master A, 1 = master B
    logic [1:0]       state_q,      state_d;
    logic             owner_q,      owner_d;
    logic             rr_last_q,    rr_last_d;
    logic             la_req_q,     la_req_d;
    logic             la_pend_q,    la_pend_d;
    logic [TMO_W-1:0] wdog_q,       wdog_d;
    logic             m_act_q,      m_act_d;
    logic             m_we_q,       m_we_d;
    logic [SW-1:0]    m_sel_q,      m_sel_d;
    logic [AW-1:0]    m_adr_q,      m_adr_d;
    logic [DW-1:0]    m_dat_q,      m_dat_d;
    logic [DW-1:0]    wbs_dat_q,    wbs_dat_d;
    logic             wbs_ack_q,    wbs_ack_d;
    logic [DW-1:0]    la_dat_q,     la_dat_d;
    logic             la_done_q,    la_done_d;
    logic             la_err_q,     la_err_d;
    logic             tmo_sticky_q, tmo_sticky_d;

    logic             req_a;
    logic             req_b;
    logic             pick_b;
    logic             la_rise;
    logic             b_owner;
    logic             fin;
    logic             fin_tmo;
    logic [DW-1:0]    fin_dat;

    assign req_a   = wbs_cyc_i & wbs_stb_i;
    assign req_b   = la_pend_q;
    // B wins when it is alone, or on a tie when A had the previous grant
    assign pick_b  = req_b & (~req_a | ~rr_last_q);
    assign la_rise = la_req_i & ~la_req_q;
    // B keeps ownership through DONE; edges seen then must not queue a second transaction
    assign b_owner = (state_q != ST_IDLE) & owner_q;

    // Arbitration, downstream cycle tracking, watchdog and completion reporting
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_last_d    = rr_last_q;
        la_req_d     = la_req_i;
        la_pend_d    = la_pend_q;
        wdog_d       = wdog_q;
        m_act_d      = m_act_q;
        m_we_d       = m_we_q;
        m_sel_d      = m_sel_q;
        m_adr_d      = m_adr_q;
        m_dat_d      = m_dat_q;
        wbs_dat_d    = wbs_dat_q;
        wbs_ack_d    = 1'b0;
        la_dat_d     = la_dat_q;
        la_done_d    = 1'b0;
        la_err_d     = 1'b0;
        tmo_sticky_d = tmo_sticky_q;
        fin          = 1'b0;
        fin_tmo      = 1'b0;
        fin_dat      = m_dat_i;

        if (la_rise && !la_pend_q && !b_owner) begin
            la_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    owner_d   = pick_b;
                    rr_last_d = pick_b;
                    m_act_d   = 1'b1;
                    wdog_d    = '0;
                    state_d   = ST_BUSY;
                    if (pick_b) begin
                        la_pend_d = 1'b0;
                        m_we_d    = la_we_i;
                        m_sel_d   = la_sel_i;
                        m_adr_d   = la_adr_i;
                        m_dat_d   = la_dat_i;
                    end else begin
                        m_we_d    = wbs_we_i;
                        m_sel_d   = wbs_sel_i;
                        m_adr_d   = wbs_adr_i;
                        m_dat_d   = wbs_dat_i;
                    end
                end
            end
            ST_BUSY: begin
                // an ack arriving in the expiry cycle still counts as a normal completion
                if (m_ack_i) begin
                    fin     = 1'b1;
                    fin_dat = m_dat_i;
                end else if (wdog_q == WD_EXPIRE) begin
                    fin          = 1'b1;
                    fin_tmo      = 1'b1;
                    fin_dat      = ERR_DATA;
                    tmo_sticky_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (fin) begin
                    m_act_d = 1'b0;
                    state_d = ST_DONE;
                    if (owner_q) begin
                        la_dat_d  = fin_dat;
                        la_done_d = 1'b1;
                        la_err_d  = fin_tmo;
                    end else begin
                        wbs_dat_d = fin_dat;
                        wbs_ack_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // master A drops stb on this edge, so IDLE never sees the finished request
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any downstream cycle immediately and issues no ack
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            rr_last_q    <= 1'b1;
            la_req_q     <= 1'b0;
            la_pend_q    <= 1'b0;
            wdog_q       <= '0;
            m_act_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_sel_q      <= '0;
            m_adr_q      <= '0;
            m_dat_q      <= '0;
            wbs_dat_q    <= '0;
            wbs_ack_q    <= 1'b0;
            la_dat_q     <= '0;
            la_done_q    <= 1'b0;
            la_err_q     <= 1'b0;
            tmo_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_last_q    <= rr_last_d;
            la_req_q     <= la_req_d;
            la_pend_q    <= la_pend_d;
            wdog_q       <= wdog_d;
            m_act_q      <= m_act_d;
            m_we_q       <= m_we_d;
            m_sel_q      <= m_sel_d;
            m_adr_q      <= m_adr_d;
            m_dat_q      <= m_dat_d;
            wbs_dat_q    <= wbs_dat_d;
            wbs_ack_q    <= wbs_ack_d;
            la_dat_q     <= la_dat_d;
            la_done_q    <= la_done_d;
            la_err_q     <= la_err_d;
            tmo_sticky_q <= tmo_sticky_d;
        end
    end

    assign m_cyc_o      = m_act_q;
    assign m_stb_o      = m_act_q;
    assign m_we_o       = m_we_q;
    assign m_sel_o      = m_sel_q;
    assign m_adr_o      = m_adr_q;
    assign m_dat_o      = m_dat_q;
    assign wbs_dat_o    = wbs_dat_q;
    assign wbs_ack_o    = wbs_ack_q;
    assign la_dat_o     = la_dat_q;
    assign la_done_o    = la_done_q;
    assign la_err_o     = la_err_q;
    assign tmo_sticky_o = tmo_sticky_q;
    assign grant_o      = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

endmodule
